sram_loop_sequencer: RTL and testbench

Sequences the external 256K×8 asynchronous SRAM for the record/playback video path. Each pixel slot is one fixed-length SRAM access: a write of the incoming 1-bit-derived pixel byte in record mode, or a read in playback mode. The block owns the address counter, including loop-region wrap and externally requested jumps. It sits between the RPi pixel front end and the VGA output stage, and replaces free-running address/WE generation with registered, contention-free strobes. The top level builds the `io` tristate from `sram_dq_o`/`sram_dq_oe`.

---
 rtl/sram_seq_pkg.sv | 13 +
 rtl/sram_addr_gen.sv | 70 +++++++
 rtl/sram_loop_sequencer.sv | 105 ++++++++++
 tb/tb_sram_loop_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_seq_pkg.sv
// Shared defaults and slot-state encodings for the SRAM loop sequencer.
package sram_seq_pkg;

    localparam int unsigned ADDR_W_DEF = 18;
    localparam int unsigned DATA_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t WR_SLOT = 2'd1;
    localparam state_t RD_SLOT = 2'd2;

endpackage

// File: rtl/sram_addr_gen.sv
// SRAM address counter: loop-region wrap, frame-sync restart and latched jumps.
module sram_addr_gen
    import sram_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              frame_sync,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [ADDR_W-1:0] loop_start,
    input  logic [ADDR_W-1:0] loop_end,
    output logic [ADDR_W-1:0] addr,
    output logic              jump_ack
);

    logic              jmp_pend;
    logic [ADDR_W-1:0] jmp_tgt;
    logic              fs_pend;

    logic              jump_now;
    logic [ADDR_W-1:0] tgt_now;
    logic              fs_now;
    logic [ADDR_W-1:0] addr_nx;

    // A request arriving on the slot-end edge itself is honoured on that edge.
    always_comb begin
        jump_now = jmp_pend | jump_req;
        tgt_now  = jump_req ? jump_addr : jmp_tgt;
        fs_now   = fs_pend | frame_sync;
        if (jump_now) begin
            addr_nx = tgt_now;
        end else if (fs_now) begin
            addr_nx = loop_start;
        end else if (addr == loop_end) begin
            addr_nx = loop_start;
        end else begin
            addr_nx = addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr     <= '0;
            jmp_pend <= 1'b0;
            jmp_tgt  <= '0;
            fs_pend  <= 1'b0;
            jump_ack <= 1'b0;
        end else begin
            jump_ack <= 1'b0;
            if (jump_req) begin
                jmp_pend <= 1'b1;
                jmp_tgt  <= jump_addr;
            end
            if (frame_sync) begin
                fs_pend <= 1'b1;
            end
            // Applying any advance consumes both pending events; a jump discards frame_sync.
            if (advance) begin
                addr     <= addr_nx;
                jmp_pend <= 1'b0;
                fs_pend  <= 1'b0;
                jump_ack <= jump_now;
            end
        end
    end

endmodule

// File: rtl/sram_loop_sequencer.sv
// Fixed-length SRAM access slots (write in record, read in playback) with
// registered, contention-free strobes.
module sram_loop_sequencer
    import sram_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DIV    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              rec,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              frame_sync,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [ADDR_W-1:0] loop_start,
    input  logic [ADDR_W-1:0] loop_end,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_cs_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_valid,
    output logic              jump_ack
);

    localparam int unsigned PH_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);

    state_t          state;
    state_t          state_nx;
    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_nx;
    logic            slot_end;
    logic            boundary;

    always_comb begin
        slot_end = (state != IDLE) && (ph == PH_LAST);
        boundary = (state == IDLE) || (ph == PH_LAST);
        if (boundary) begin
            ph_nx = '0;
            if (!en) begin
                state_nx = IDLE;
            end else if (rec) begin
                state_nx = WR_SLOT;
            end else begin
                state_nx = RD_SLOT;
            end
        end else begin
            ph_nx    = ph + PH_W'(1);
            state_nx = state;
        end
    end

    // Strobes are decoded from the next state/phase so each register shows
    // the value belonging to the cycle it is presented in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ph         <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_cs_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            pix_out    <= '0;
            pix_valid  <= 1'b0;
        end else begin
            state      <= state_nx;
            ph         <= ph_nx;
            sram_cs_n  <= (state_nx == IDLE);
            sram_dq_oe <= (state_nx == WR_SLOT) && (ph_nx != '0);
            sram_we_n  <= !((state_nx == WR_SLOT) && (ph_nx != '0) && (ph_nx != PH_LAST));
            sram_oe_n  <= !((state_nx == RD_SLOT) && (ph_nx != '0));
            if ((state_nx == WR_SLOT) && (ph_nx == '0)) begin
                sram_dq_o <= pix_in;
            end
            pix_valid <= (state == RD_SLOT) && (ph == PH_LAST);
            if ((state == RD_SLOT) && (ph == PH_LAST)) begin
                pix_out <= sram_dq_i;
            end
        end
    end

    sram_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (slot_end),
        .frame_sync (frame_sync),
        .jump_req   (jump_req),
        .jump_addr  (jump_addr),
        .loop_start (loop_start),
        .loop_end   (loop_end),
        .addr       (sram_addr),
        .jump_ack   (jump_ack)
    );

endmodule

// File: tb/tb_sram_loop_sequencer.sv
// Self-checking bench for sram_loop_sequencer: slot-level reference model plus
// a behavioural SRAM driven by the DUT strobes.
module tb_sram_loop_sequencer;

    localparam int DIV   = 4;
    localparam int AW    = 18;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          rec = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic          frame_sync = 1'b0;
    logic          jump_req = 1'b0;
    logic [AW-1:0] jump_addr = '0;
    logic [AW-1:0] loop_start = '0;
    logic [AW-1:0] loop_end = '1;
    logic [DW-1:0] sram_dq_i;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_o;
    logic          sram_dq_oe;
    logic          sram_cs_n;
    logic          sram_we_n;
    logic          sram_oe_n;
    logic [DW-1:0] pix_out;
    logic          pix_valid;
    logic          jump_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_loop_sequencer #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DIV    (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .rec        (rec),
        .pix_in     (pix_in),
        .frame_sync (frame_sync),
        .jump_req   (jump_req),
        .jump_addr  (jump_addr),
        .loop_start (loop_start),
        .loop_end   (loop_end),
        .sram_dq_i  (sram_dq_i),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_cs_n  (sram_cs_n),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .jump_ack   (jump_ack)
    );

    // Behavioural asynchronous SRAM: stores whatever is on the bus while WE is low.
    logic [DW-1:0] sram_mem [0:DEPTH-1];
    bit            sram_init = 1'b0;

    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] = '0;
            sram_init = 1'b1;
        end
        if (!sram_cs_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_o;
    end

    assign sram_dq_i = (!sram_cs_n && !sram_oe_n) ? sram_mem[sram_addr] : 8'hEE;

    // Reference model: slot kind (0 idle, 1 write, 2 read), clocks into the slot,
    // address pointer, pending events and the memory contents it expects.
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    int            m_kind = 0;
    int            m_k = 0;
    logic [AW-1:0] m_addr = '0;
    bit            m_jp = 1'b0;
    logic [AW-1:0] m_jt = '0;
    bit            m_fs = 1'b0;
    logic [DW-1:0] m_dq = '0;
    logic [DW-1:0] m_pix = '0;
    bit            m_valid = 1'b0;
    bit            m_ack = 1'b0;
    logic [AW-1:0] got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit slot_done;
        m_valid = 1'b0;
        m_ack   = 1'b0;
        if (!rst_n) begin
            m_kind = 0; m_k = 0; m_addr = '0; m_jp = 1'b0; m_jt = '0;
            m_fs = 1'b0; m_dq = '0; m_pix = '0;
            return;
        end
        slot_done = (m_kind != 0) && (m_k == DIV - 1);
        if (slot_done) begin
            if (m_kind == 1) ref_mem[m_addr] = m_dq;
            if (m_kind == 2) begin
                m_pix   = ref_mem[m_addr];
                m_valid = 1'b1;
            end
            if (m_jp || jump_req) begin
                m_addr = jump_req ? jump_addr : m_jt;
                m_ack  = 1'b1;
            end else if (m_fs || frame_sync) begin
                m_addr = loop_start;
            end else if (m_addr == loop_end) begin
                m_addr = loop_start;
            end else begin
                m_addr = m_addr + 18'd1;
            end
            m_jp = 1'b0;
            m_fs = 1'b0;
        end else begin
            if (jump_req) begin
                m_jp = 1'b1;
                m_jt = jump_addr;
            end
            if (frame_sync) m_fs = 1'b1;
        end
        if (m_kind == 0 || slot_done) begin
            m_kind = !en ? 0 : (rec ? 1 : 2);
            m_k    = 0;
            if (m_kind == 1) m_dq = pix_in;
        end else begin
            m_k++;
        end
    endtask

    task automatic check_all();
        chk("addr", 32'(sram_addr), 32'(m_addr));
        chk("cs_n", 32'(sram_cs_n), 32'(m_kind == 0));
        chk("we_n", 32'(sram_we_n), 32'(!(m_kind == 1 && m_k >= 1 && m_k <= DIV - 2)));
        chk("dq_oe", 32'(sram_dq_oe), 32'(m_kind == 1 && m_k >= 1));
        chk("oe_n", 32'(sram_oe_n), 32'(!(m_kind == 2 && m_k >= 1)));
        chk("dq_o", 32'(sram_dq_o), 32'(m_dq));
        chk("pix_out", 32'(pix_out), 32'(m_pix));
        chk("pix_valid", 32'(pix_valid), 32'(m_valid));
        chk("jump_ack", 32'(jump_ack), 32'(m_ack));
        chk("no_contention", 32'(sram_dq_oe & ~sram_oe_n), 32'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_phase(input int kind, input int k, input string tag);
        bit hit;
        for (int g = 0; g < 4 * DIV + 4 && !(m_kind == kind && m_k == k); g++) tick();
        hit = (m_kind == kind && m_k == k);
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL %s observed=timeout expected=kind%0d_ph%0d", tag, kind, k);
        end
    endtask

    task automatic wait_ack(input string tag);
        for (int g = 0; g < 3 * DIV && !jump_ack; g++) tick();
        chk(tag, 32'(jump_ack), 32'(1));
    endtask

    task automatic collect(input int n);
        got.delete();
        for (int g = 0; g < 8 * DIV * n && got.size() < n; g++) begin
            if (m_kind != 0 && m_k == 0) got.push_back(sram_addr);
            tick();
        end
    endtask

    task automatic pulse_jump(input logic [AW-1:0] a, input logic fs);
        jump_req   = 1'b1;
        jump_addr  = a;
        frame_sync = fs;
        tick();
        jump_req   = 1'b0;
        frame_sync = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] exp_loop [5];
        logic [AW-1:0] exp_inv  [5];
        exp_loop = '{18'h10, 18'h11, 18'h12, 18'h13, 18'h10};
        exp_inv  = '{18'h3FFFE, 18'h3FFFF, 18'h0, 18'h1, 18'h3FFFE};
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Reset state
        run(3);
        chk("reset_addr", 32'(sram_addr), 32'(0));
        chk("reset_we_n", 32'(sram_we_n), 32'(1));
        rst_n = 1'b1;
        run(2);

        // Record alternating 0xFF / 0x00 from address 0
        en = 1'b1;
        rec = 1'b1;
        for (int s = 0; s < 8; s++) begin
            pix_in = s[0] ? 8'h00 : 8'hFF;
            run(DIV);
        end

        // Playback restarted from loop_start by frame_sync
        rec = 1'b0;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        run(10 * DIV);
        chk("playback_data", 32'(pix_out), 32'(ref_mem[7]));

        // Loop region 0x10..0x13
        loop_start = 18'h10;
        loop_end   = 18'h13;
        pulse_jump(18'h10, 1'b0);
        wait_ack("loop_jump_ack");
        collect(5);
        for (int i = 0; i < 5; i++) chk($sformatf("loop_seq%0d", i), 32'(got[i]), 32'(exp_loop[i]));

        // Inverted loop region wrapping through the top of memory
        loop_start = 18'h3FFFE;
        loop_end   = 18'h00001;
        pulse_jump(18'h3FFFE, 1'b0);
        wait_ack("inv_jump_ack");
        collect(5);
        for (int i = 0; i < 5; i++) chk($sformatf("inv_seq%0d", i), 32'(got[i]), 32'(exp_inv[i]));

        // Jump beats frame_sync in the same slot; later request overwrites
        loop_start = 18'h0;
        loop_end   = 18'h3FFFF;
        wait_phase(2, 1, "wait_jump1");
        pulse_jump(18'h200, 1'b1);
        wait_ack("jump200_ack");
        chk("jump200_addr", 32'(sram_addr), 32'(18'h200));
        wait_phase(2, 0, "wait_jump2");
        pulse_jump(18'h200, 1'b0);
        pulse_jump(18'h300, 1'b0);
        wait_ack("jump300_ack");
        chk("jump300_addr", 32'(sram_addr), 32'(18'h300));
        run(3 * DIV);

        // rec drops at ph 2 of a write: write completes, turnaround before the read
        rec = 1'b1;
        wait_phase(1, 2, "wait_wr_ph2");
        rec = 1'b0;
        wait_phase(2, 0, "wait_turnaround");
        chk("turn_dq_oe", 32'(sram_dq_oe), 32'(0));
        chk("turn_oe_n", 32'(sram_oe_n), 32'(1));
        chk("turn_cs_n", 32'(sram_cs_n), 32'(0));
        tick();
        chk("turn_read_oe_n", 32'(sram_oe_n), 32'(0));

        // Randomized traffic
        for (int blk = 0; blk < 6; blk++) begin
            loop_start = AW'($urandom_range(0, 40));
            loop_end   = AW'($urandom_range(0, 40));
            for (int c = 0; c < 100; c++) begin
                en         = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 29) == 0) rec = ~rec;
                pix_in     = DW'($urandom);
                jump_req   = ($urandom_range(0, 19) == 0);
                jump_addr  = AW'($urandom_range(0, 60));
                frame_sync = ($urandom_range(0, 14) == 0);
                tick();
            end
        end
        jump_req   = 1'b0;
        frame_sync = 1'b0;

        // Reset during a write at ph 1
        en  = 1'b1;
        rec = 1'b1;
        wait_phase(1, 1, "wait_wr_ph1");
        rst_n = 1'b0;
        tick();
        chk("rst_we_n", 32'(sram_we_n), 32'(1));
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'(0));
        chk("rst_cs_n", 32'(sram_cs_n), 32'(1));
        chk("rst_addr", 32'(sram_addr), 32'(0));
        rst_n = 1'b1;
        en    = 1'b0;
        run(8);
        chk("idle_cs_n", 32'(sram_cs_n), 32'(1));
        chk("idle_addr", 32'(sram_addr), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
